// File: rtl/logic_seq_if.sv
// Operand/result handshake bundle for the sequential logic unit.
// The master issues operands and accepts results; the slave is the sequencer.
interface logic_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             zero;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, s, zero
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, s, zero
    );
endinterface

// File: rtl/logic_seq_ctrl.sv
// Slice-serial 32-bit AND/OR/XOR/NOR unit: one SLICE-wide slice per cycle, NSL cycles per op.
// Optional zero flag accumulator is enabled by defining LOGIC_SEQ_ZERO_EN.
module logic_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    logic_seq_if.slave    bus
);

    localparam int NSL   = WIDTH / SLICE;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [1:0]       opr;
    logic [31:0]      sl_base;
    logic [SLICE-1:0] slice_res;
    logic             accept;
    logic             run_last;

    function automatic logic [SLICE-1:0] slice_logic(
        input logic [1:0]       f,
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b
    );
        logic [SLICE-1:0] r;
        case (f)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    assign accept    = (state_q == S_IDLE) && bus.in_valid && !flush;
    assign run_last  = (idx_q == IDX_LAST);
    assign sl_base   = 32'(idx_q) * SLICE;
    assign slice_res = slice_logic(opr, xr[sl_base +: SLICE], yr[sl_base +: SLICE]);

    // ---- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_RUN;
            S_RUN:   if (run_last)     state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // ---- Operand capture: contents only matter after an accept, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            xr  <= bus.x;
            yr  <= bus.y;
            opr <= bus.op;
        end
    end

    // ---- Slice datapath: result register and slice index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            idx_q <= '0;
        end else if (flush) begin
            s_q   <= '0;
            idx_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        s_q   <= '0;
                        idx_q <= '0;
                    end
                end
                S_RUN: begin
                    s_q[sl_base +: SLICE] <= slice_res;
                    idx_q <= run_last ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOGIC_SEQ_ZERO_EN
    logic zacc_q;

    // ---- Zero accumulator: tracks "every slice so far was zero"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zacc_q <= 1'b0;
        end else if (flush) begin
            zacc_q <= 1'b0;
        end else if (accept) begin
            zacc_q <= 1'b1;
        end else if (state_q == S_RUN) begin
            zacc_q <= zacc_q & (slice_res == '0);
        end
    end
`endif

    // ---- FSM: outputs are pure state decodes
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
`ifdef LOGIC_SEQ_ZERO_EN
        bus.zero      = (state_q == S_DONE) && zacc_q;
`else
        bus.zero      = 1'b0;
`endif
    end

    assign bus.s = s_q;

endmodule

// File: doc/logic_seq_ctrl.md
# logic_seq_ctrl

Multi-cycle sequencer that computes a 32-bit bitwise logic operation (AND/OR/XOR/NOR) by driving one SLICE-wide logic slice over WIDTH/SLICE consecutive cycles. It sits in the ALU's logic path as an area-reduced alternative to the fully parallel 32-bit logic unit. Operands and results pass over valid/ready handshakes, so the execute stage can stall on it.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE
- SLICE, 8, bits processed per cycle; NSL = WIDTH/SLICE slices (4 at defaults)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; highest priority after reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept an operand; high only in IDLE
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR; sampled with x and y
- x, y  in  WIDTH  operands
- out_valid  out  1  result s is final
- out_ready  in  1  consumer accepts the result
- s  out  WIDTH  result register
- zero  out  1  s == 0 flag, valid with out_valid (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE. Slice index idx is a counter of width clog2(NSL).
- IDLE: in_ready=1. On in_valid, latch x, y and op into operand registers, clear s to 0, set idx=0, and go to RUN.
- RUN: each cycle, compute slice idx, s[idx*SLICE +: SLICE] = f(op, xr slice, yr slice), and write it. Other slices hold. idx increments. After the idx==NSL-1 write, go to DONE and reset idx to 0.
- DONE: out_valid=1 and s is stable. When out_ready=1, go to IDLE. Otherwise hold indefinitely.
- NOR is computed per slice as ~(x|y).
- Input changes while not in IDLE are ignored because operands are latched.
- flush in any state: go to IDLE, set out_valid=0, s=0, idx=0. Operand registers are don't-care. flush and in_valid in the same cycle: flush wins and nothing is accepted.
- rst_n low at any time, including mid-RUN: the block immediately enters IDLE with all outputs at reset values. No partial result survives.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, zero=0, idx=0.
- Accept occurs at clock edge E0, where in_valid and in_ready are both high. Slices 0..NSL-1 are written at edges E1..E_NSL.
- out_valid rises after edge E_NSL, giving a latency of NSL cycles (4 at defaults).
- The result handshake completes on the edge where out_valid and out_ready are both high. in_ready rises after that edge.
- Back-to-back throughput is one operation per NSL+2 cycles when out_ready is held high.
- in_ready and out_valid are never high in the same cycle.
- During RUN, s is observable with upper slices still 0. Consumers use s only while out_valid=1.
- in_ready and out_valid are registered state decodes. There are no combinational paths from in_valid or out_ready to any output.

## Configuration
- Macro: LOGIC_SEQ_ZERO_EN.
- Defined: a zero accumulator is set to 1 on accept. In each RUN cycle it is ANDed with (computed slice == 0). zero drives the accumulator value in DONE and 0 otherwise. The zero port adds no latency.
- Undefined: zero is tied to 0 and the accumulator logic is absent. The port list is identical either way.

## Test plan
- Reset: with rst_n=0, check in_ready=1, out_valid=0, s=0. After release, accept x=0xF0F0_1234, y=0xFF00_00FF, op=00. out_valid must rise exactly 4 cycles after accept with s=0xF000_0034.
- Op sweep on the same operands: OR gives 0xFFF0_12FF, XOR gives 0x0FF0_12CB. NOR with x=y=0 gives 0xFFFF_FFFF. Check zero=0 in all three cases.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. s and out_valid must stay stable and in_ready must stay 0. Raise out_ready: in_ready=1 on the next cycle. A new in_valid held throughout is accepted only then.
- Mid-op abort: assert flush in the 2nd RUN cycle. On the next cycle state=IDLE, s=0, out_valid=0. Then accept x=0xA5A5_A5A5, y=0x5A5A_5A5A, op=00; the result must be s=0 with zero=1 when LOGIC_SEQ_ZERO_EN is defined, and zero=0 otherwise.
- Async reset: drop rst_n asynchronously between edges during RUN. Outputs must reach reset values before the next edge, and a subsequent operation must complete correctly.
- Operand isolation: change x, y and op every cycle during RUN. The result must match only the operands latched at accept.
